// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC select, return stack and a
// single-level interrupt entry/return path.
//
// Ports:
//   clk_i, rst_ni     clock, async active-low reset
//   step_i            retire current instruction, advance PC
//   op_i, cond_i      instruction class and branch condition
//   zero_i, carry_i   datapath flags sampled on a step
//   offset_i, addr_i  signed branch offset, jmp/jsb target
//   int_req_i         level interrupt request
//   pc_o, pcoper_o    PC register, combinational next-PC selector
//   stackaddr_o       top-of-stack entry (0 when empty)
//   intpc_o           saved interrupt return PC
//   int_ack_o, ie_o   interrupt-taken pulse, interrupt enable
//   stack_ovf_o/unf_o sticky stack overflow/underflow
module pc_sequencer #(
    parameter int          DEPTH  = 8,
    parameter logic [11:0] VECTOR = 12'h001
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        step_i,
    input  logic [2:0]  op_i,
    input  logic [1:0]  cond_i,
    input  logic        zero_i,
    input  logic        carry_i,
    input  logic [7:0]  offset_i,
    input  logic [11:0] addr_i,
    input  logic        int_req_i,
    output logic [11:0] pc_o,
    output logic [3:0]  pcoper_o,
    output logic [11:0] stackaddr_o,
    output logic [11:0] intpc_o,
    output logic        int_ack_o,
    output logic        ie_o,
    output logic        stack_ovf_o,
    output logic        stack_unf_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = AW + 1;
    localparam logic [SW-1:0] SP_FULL = SW'(DEPTH);

    localparam logic [2:0] OP_SEQ  = 3'b000;
    localparam logic [2:0] OP_BR   = 3'b001;
    localparam logic [2:0] OP_JMP  = 3'b010;
    localparam logic [2:0] OP_JSB  = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_RETI = 3'b101;
    localparam logic [2:0] OP_ENAI = 3'b110;
    localparam logic [2:0] OP_DISI = 3'b111;

    typedef enum logic {
        RUN,
        ISR
    } state_t;

    state_t state_q, state_d;

    logic [11:0]   pc_q, pc_d;
    logic [11:0]   intpc_q, intpc_d;
    logic [11:0]   inst_npc;
    logic [11:0]   stack_q [DEPTH];
    logic [SW-1:0] sp_q;
    logic          ie_q, ie_d;
    logic          ack_q;
    logic          ovf_q, unf_q;
    logic          ovf_set, unf_set;
    logic          push, pop;
    logic          take_int;
    logic          cond_ok;
    logic [AW-1:0] top_idx;
    logic [11:0]   top_val;
    logic [11:0]   pc_inc;
    logic [11:0]   br_tgt;

    assign pc_inc  = pc_q + 12'd1;
    assign br_tgt  = pc_q + {{4{offset_i[7]}}, offset_i};
    assign top_idx = AW'(sp_q - SW'(1));
    assign top_val = stack_q[top_idx];

    // reti is never interrupted so the return always lands first.
    assign take_int = step_i && int_req_i && ie_q
                    && (op_i != OP_RETI);

    always_comb begin
        cond_ok = 1'b0;
        unique case (cond_i)
            2'b00: cond_ok = zero_i;
            2'b01: cond_ok = !zero_i;
            2'b10: cond_ok = carry_i;
            2'b11: cond_ok = !carry_i;
        endcase
    end

    // Instruction result first; an interrupt then redirects it,
    // saving the instruction's own next PC as the return point.
    always_comb begin
        inst_npc = pc_inc;
        pcoper_o = 4'b0000;
        push     = 1'b0;
        pop      = 1'b0;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        ie_d     = ie_q;
        unique case (op_i)
            OP_SEQ: begin
            end
            OP_BR: begin
                pcoper_o = {2'b01, cond_i};
                if (cond_ok) inst_npc = br_tgt;
            end
            OP_JMP: begin
                pcoper_o = 4'b1000;
                inst_npc = addr_i;
            end
            OP_JSB: begin
                pcoper_o = 4'b1000;
                inst_npc = addr_i;
                if (sp_q == SP_FULL) ovf_set = 1'b1;
                else                 push    = 1'b1;
            end
            OP_RET: begin
                pcoper_o = 4'b1010;
                if (sp_q == '0) begin
                    unf_set = 1'b1;
                end else begin
                    pop      = 1'b1;
                    inst_npc = top_val;
                end
            end
            OP_RETI: begin
                pcoper_o = 4'b1100;
                inst_npc = intpc_q;
                ie_d     = 1'b1;
            end
            OP_ENAI: ie_d = 1'b1;
            OP_DISI: ie_d = 1'b0;
        endcase
        pc_d    = inst_npc;
        intpc_d = intpc_q;
        if (take_int) begin
            pcoper_o = 4'b1000;
            pc_d     = VECTOR;
            intpc_d  = inst_npc;
            ie_d     = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: if (take_int) state_d = ISR;
            ISR: begin
                if (take_int)
                    state_d = ISR;
                else if (step_i && op_i == OP_RETI)
                    state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            pc_q    <= '0;
            intpc_q <= '0;
            sp_q    <= '0;
            ie_q    <= 1'b0;
            ack_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                stack_q[i] <= '0;
        end else begin
            ack_q   <= take_int;
            state_q <= state_d;
            if (step_i) begin
                pc_q    <= pc_d;
                intpc_q <= intpc_d;
                ie_q    <= ie_d;
                if (push) begin
                    stack_q[sp_q[AW-1:0]] <= pc_inc;
                    sp_q <= sp_q + SW'(1);
                end else if (pop) begin
                    sp_q <= sp_q - SW'(1);
                end
                if (ovf_set) ovf_q <= 1'b1;
                if (unf_set) unf_q <= 1'b1;
            end
        end
    end

    assign pc_o        = pc_q;
    assign stackaddr_o = (sp_q == '0) ? 12'h000 : top_val;
    assign intpc_o     = intpc_q;
    assign int_ack_o   = ack_q;
    assign ie_o        = ie_q;
    assign stack_ovf_o = ovf_q;
    assign stack_unf_o = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a behavioural model pushes the
// expected state per step to a queue, popped after the clock edge.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        step = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [1:0]  cond = 2'b00;
    logic        zero = 1'b0;
    logic        carry = 1'b0;
    logic [7:0]  offset = 8'h00;
    logic [11:0] addr = 12'h000;
    logic        int_req = 1'b0;
    logic [11:0] pc, stackaddr, intpc;
    logic [3:0]  pcoper;
    logic        int_ack, ie, ovf, unf;

    always #5 clk = ~clk;

    pc_sequencer #(.DEPTH(8), .VECTOR(12'h001)) dut (
        .clk_i(clk), .rst_ni(rst_n), .step_i(step), .op_i(op),
        .cond_i(cond), .zero_i(zero), .carry_i(carry),
        .offset_i(offset), .addr_i(addr), .int_req_i(int_req),
        .pc_o(pc), .pcoper_o(pcoper), .stackaddr_o(stackaddr),
        .intpc_o(intpc), .int_ack_o(int_ack), .ie_o(ie),
        .stack_ovf_o(ovf), .stack_unf_o(unf)
    );

    typedef struct packed {
        logic [11:0] pc;
        logic [11:0] stk;
        logic [11:0] intpc;
        logic        ie, ovf, unf, ack;
    } exp_t;

    exp_t        sb[$];
    logic [11:0] m_pc, m_intpc;
    logic [11:0] m_stk[$];
    logic        m_ie, m_ovf, m_unf, m_ack;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic exp_t snap();
        exp_t e;
        e.pc    = m_pc;
        e.stk   = (m_stk.size() == 0) ? 12'h000 : m_stk[$];
        e.intpc = m_intpc;
        e.ie    = m_ie;
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        e.ack   = m_ack;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs,
                       input logic [11:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input exp_t e);
        chk({tag, ".pc"}, pc, e.pc);
        chk({tag, ".stk"}, stackaddr, e.stk);
        chk({tag, ".intpc"}, intpc, e.intpc);
        chk({tag, ".ie"}, {11'h0, ie}, {11'h0, e.ie});
        chk({tag, ".ovf"}, {11'h0, ovf}, {11'h0, e.ovf});
        chk({tag, ".unf"}, {11'h0, unf}, {11'h0, e.unf});
        chk({tag, ".ack"}, {11'h0, int_ack}, {11'h0, e.ack});
    endtask

    task automatic model_reset();
        m_pc = '0; m_intpc = '0; m_stk.delete();
        m_ie = 0; m_ovf = 0; m_unf = 0; m_ack = 0;
        sb.delete();
    endtask

    task automatic do_step(input string tag, input logic [2:0] o,
                           input logic [1:0] cd, input logic z,
                           input logic cy, input logic [7:0] off,
                           input logic [11:0] a, input logic irq);
        logic [11:0] npc;
        logic [3:0]  epo;
        logic        take, ien, ok;
        @(negedge clk);
        op = o; cond = cd; zero = z; carry = cy;
        offset = off; addr = a; int_req = irq; step = 1'b1;
        take = irq && m_ie && (o != 3'b101);
        npc  = m_pc + 12'd1;
        ien  = m_ie;
        epo  = 4'b0000;
        case (o)
            3'b001: begin
                epo = {2'b01, cd};
                case (cd)
                    2'b00:   ok = z;
                    2'b01:   ok = !z;
                    2'b10:   ok = cy;
                    default: ok = !cy;
                endcase
                if (ok) npc = m_pc + {{4{off[7]}}, off};
            end
            3'b010: begin epo = 4'b1000; npc = a; end
            3'b011: begin
                epo = 4'b1000; npc = a;
                if (m_stk.size() == 8) m_ovf = 1'b1;
                else m_stk.push_back(m_pc + 12'd1);
            end
            3'b100: begin
                epo = 4'b1010;
                if (m_stk.size() == 0) m_unf = 1'b1;
                else npc = m_stk.pop_back();
            end
            3'b101: begin epo = 4'b1100; npc = m_intpc; ien = 1'b1; end
            3'b110: ien = 1'b1;
            3'b111: ien = 1'b0;
            default: ;
        endcase
        if (take) begin
            epo = 4'b1000; m_intpc = npc; m_pc = 12'h001; ien = 1'b0;
        end else begin
            m_pc = npc;
        end
        m_ie = ien; m_ack = take;
        sb.push_back(snap());
        #1 chk({tag, ".pcoper"}, {8'h0, pcoper}, {8'h0, epo});
        @(posedge clk);
        #1;
        step = 1'b0; int_req = 1'b0;
        chk_state(tag, sb.pop_front());
    endtask

    task automatic idle(input string tag, input logic [2:0] o,
                        input logic [3:0] epo);
        @(negedge clk);
        op = o; step = 1'b0;
        #1 chk({tag, ".pcoper"}, {8'h0, pcoper}, {8'h0, epo});
        @(posedge clk);
        #1;
        m_ack = 1'b0;
        chk_state(tag, snap());
    endtask

    initial begin
        model_reset();
        #1 chk_state("por", snap());
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        idle("hold0", 3'b010, 4'b1000);
        idle("hold1", 3'b100, 4'b1010);

        do_step("jmp010", 3'b010, 0, 0, 0, 8'h00, 12'h010, 0);
        do_step("brz_t", 3'b001, 2'b00, 1, 0, 8'hFC, 12'h000, 0);
        chk("req036a", pc, 12'h00C);
        do_step("jmp010b", 3'b010, 0, 0, 0, 8'h00, 12'h010, 0);
        do_step("brz_n", 3'b001, 2'b00, 0, 0, 8'hFC, 12'h000, 0);
        chk("req036b", pc, 12'h011);
        do_step("brnz", 3'b001, 2'b01, 0, 0, 8'h05, 12'h000, 0);
        do_step("brc", 3'b001, 2'b10, 0, 1, 8'h80, 12'h000, 0);
        do_step("brnc", 3'b001, 2'b11, 0, 1, 8'h80, 12'h000, 0);
        do_step("jmpfff", 3'b010, 0, 0, 0, 8'h00, 12'hFFF, 0);
        do_step("wrap", 3'b000, 0, 0, 0, 8'h00, 12'h000, 0);
        chk("req037a", pc, 12'h000);
        do_step("jmp3a0", 3'b010, 0, 0, 0, 8'h00, 12'h3A0, 0);
        chk("req037b", pc, 12'h3A0);
        idle("hold2", 3'b001, 4'b0100);

        do_step("jmp100", 3'b010, 0, 0, 0, 8'h00, 12'h100, 0);
        for (int i = 0; i < 9; i++) begin
            if (i == 8) chk("ovf_pre", {11'h0, ovf}, 12'h000);
            do_step("jsb", 3'b011, 0, 0, 0, 8'h00,
                    12'h100 + 12'(16 * (i + 1)), 0);
        end
        chk("req038_ovf", {11'h0, ovf}, 12'h001);
        chk("req038_top", stackaddr, 12'h171);
        for (int i = 0; i < 9; i++)
            do_step("ret", 3'b100, 0, 0, 0, 8'h00, 12'h000, 0);
        chk("req038_pc", pc, 12'h102);
        chk("req038_unf", {11'h0, unf}, 12'h001);

        do_step("jmp04f", 3'b010, 0, 0, 0, 8'h00, 12'h04F, 0);
        do_step("enai", 3'b110, 0, 0, 0, 8'h00, 12'h000, 0);
        do_step("jsbint", 3'b011, 0, 0, 0, 8'h00, 12'h200, 1);
        chk("req039_pc", pc, 12'h001);
        chk("req039_top", stackaddr, 12'h051);
        chk("req039_ipc", intpc, 12'h200);
        chk("req039_ack", {11'h0, int_ack}, 12'h001);
        idle("ackdrop", 3'b000, 4'b0000);
        do_step("reti", 3'b101, 0, 0, 0, 8'h00, 12'h000, 0);
        chk("req039_ret", pc, 12'h200);

        do_step("disi", 3'b111, 0, 0, 0, 8'h00, 12'h000, 0);
        do_step("reti_irq", 3'b101, 0, 0, 0, 8'h00, 12'h000, 1);
        chk("req040_noack", {11'h0, int_ack}, 12'h000);
        do_step("seq_irq", 3'b000, 0, 0, 0, 8'h00, 12'h000, 1);
        chk("req040_ipc", intpc, 12'h201);
        do_step("reti2", 3'b101, 0, 0, 0, 8'h00, 12'h000, 0);
        do_step("disi_irq", 3'b111, 0, 0, 0, 8'h00, 12'h000, 1);
        chk("req030_ipc", intpc, 12'h202);
        chk("req030_pc", pc, 12'h001);

        do_step("jmp123", 3'b010, 0, 0, 0, 8'h00, 12'h123, 0);
        do_step("jsb_r", 3'b011, 0, 0, 0, 8'h00, 12'h456, 0);
        @(negedge clk);
        step = 1'b1; op = 3'b000;
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk_state("async_rst", snap());
        step = 1'b0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        idle("post_rst", 3'b000, 4'b0000);
        do_step("first", 3'b000, 0, 0, 0, 8'h00, 12'h000, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
